mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access pipeline stage inserted between EX and WB. It accepts the EX result over the give/get handshake and issues loads/stores to a data-memory port with req/gnt/rvalid handshaking. It aligns store data, extracts and extends load data, and hands the instruction plus its final result to WB over give/get. Non-memory instructions pass through with one cycle of latency.

Parameters:
BITSIZE, 32, datapath width; only 32 is supported, and an elaboration-time assertion rejects any other value.

Ports:
clk  in  1  core clock, all state on rising edge
reset_i  in  1  synchronous reset, active-high
EX_MEM_give_i  in  1  EX holds a valid instruction/result
MEM_EX_get_o  out  1  stage accepts from EX this cycle
EX_MEM_instruction_i  in  32  instruction word
EX_MEM_d_i  in  BITSIZE  ALU result (effective address for loads/stores)
EX_MEM_rs2_i  in  BITSIZE  store data
MEM_WB_give_o  out  1  result valid for WB
WB_MEM_get_i  in  1  WB accepts this cycle
MEM_WB_instruction_o  out  32  instruction forwarded to WB
MEM_WB_d_o  out  BITSIZE  writeback data
dmem_req_o  out  1  memory request, held until granted
dmem_we_o  out  1  1 = store
dmem_addr_o  out  BITSIZE  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  BITSIZE  lane-replicated store data
dmem_gnt_i  in  1  request granted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  BITSIZE  load data
misalign_o  out  1  one-cycle pulse on misaligned or illegal access

Behaviour:
- Handshakes: a transfer occurs on a rising edge where give && get. Give and payload stay stable until the transfer completes.
- Reset (reset_i = 1 at an edge): state goes to IDLE. All outputs become 0; dmem_be_o = 0.
- Reset mid-operation: any outstanding request is abandoned. An rvalid arriving afterwards in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, OUT.
  - IDLE: MEM_EX_get_o = 1. On a transfer, latch instr, addr and rs2, then decode:
    - Non-memory opcode → OUT, MEM_WB_d_o = EX_MEM_d_i.
    - Legal load/store → REQ.
    - Misaligned access (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0) or illegal funct3 (load 011/110/111; store ≥ 011) → OUT with MEM_WB_d_o = 0 and misalign_o pulsed; no memory request is issued.
  - REQ: dmem_req_o = 1 with address, we, be and wdata stable. Transitions when dmem_gnt_i = 1:
    - store → OUT;
    - load with dmem_rvalid_i also 1 in the same cycle → OUT with data captured;
    - otherwise load → WAIT.
  - WAIT: on dmem_rvalid_i, capture the extracted data → OUT.
  - OUT: MEM_WB_give_o = 1. On WB_MEM_get_i → IDLE.
  - Pass-through in OUT: MEM_EX_get_o = WB_MEM_get_i (combinational), so a new EX transfer in the same cycle is decoded as if from IDLE, giving back-to-back throughput for ALU ops.
- Store alignment:
  - SB: be = 4'b0001 << addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << addr[1:0], wdata = {2{rs2[15:0]}}.
  - SW: be = 4'hF, wdata = rs2.
  - Stores forward EX_MEM_d_i as MEM_WB_d_o (WB ignores it, since stores have no rd).
- Loads: be follows the same rule as stores.
  - Shift dmem_rdata_i right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the value unmodified.
- Latency (req→gnt and gnt→rvalid both counted in cycles):
  - Non-memory: 1 cycle from EX transfer to MEM_WB_give_o.
  - Store: 2 + gnt wait.
  - Load: 2 + gnt wait + rvalid wait, where a same-cycle gnt and rvalid adds 0.
- All outputs except MEM_EX_get_o are registered or decoded from state. dmem_req_o never asserts outside REQ.

Decomposition:
- core_pkg:
  - opcode constants OPC_LOAD = 7'b0000011 and OPC_STORE = 7'b0100011;
  - funct3 constants for LB/LH/LW/LBU/LHU/SB/SH/SW;
  - mem_state_e enum {IDLE, REQ, WAIT, OUT}.
- Sub-module lsu_align (combinational): takes funct3, addr[1:0], rs2 and rdata; produces be, wdata, load result and the misalign flag.

Test Plan:
1. ADDI result 0x0000_0042 given, WB get held at 1 → MEM_WB_give_o high the next cycle with d = 0x42; the next ALU op is accepted in the same cycle as WB takes (no bubble).
2. SB with addr 0x103, rs2 = 0x1234_56AB, gnt after 2 cycles → req held for 3 cycles; addr 0x100, be 4'b1000, wdata 0xABAB_ABAB, we = 1; give asserts the cycle after gnt.
3. LH at 0x202 with rdata 0x8001_7FFF, gnt immediate, rvalid 3 cycles later → d = 0xFFFF_8001. LHU with the same stimulus → d = 0x0000_8001.
4. LW at 0x301 → no dmem_req_o, misalign_o pulses once, WB receives d = 0. Repeat with load funct3 = 011 → same response.
5. LW with gnt and rvalid in the same cycle, rdata 0xDEAD_BEEF → no WAIT cycle, d = 0xDEAD_BEEF. Hold WB_MEM_get_i = 0 for 4 cycles → give and payload stay stable, and MEM_EX_get_o stays 0.
6. Assert reset_i while in WAIT, then pulse rvalid after reset → state IDLE, all outputs 0, stray rvalid ignored, and the next EX instruction processes normally.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg: shared constants and types for the memory-access stage.
//   - RV32 opcode values for loads and stores
//   - funct3 encodings for the supported load/store widths
//   - mem_state_e: state encoding of the mem_stage controller
//   - is_mem_op(): true when an opcode needs the data-memory port
// ---------------------------------------------------------------------------
package core_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } mem_state_e;

  function automatic logic is_mem_op(input logic [6:0] opcode);
    return (opcode == OPC_LOAD) || (opcode == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align: purely combinational byte-lane logic for loads and stores.
//   is_store   in   1 = store, 0 = load
//   funct3     in   access width / signedness
//   addr_lo    in   byte offset within the word
//   rs2        in   raw store data
//   rdata      in   raw word returned by data memory
//   be         out  byte enables (0 for illegal/misaligned accesses)
//   wdata      out  store data replicated across the byte lanes
//   load_data  out  shifted and sign/zero-extended load result
//   misalign   out  access is misaligned or uses an illegal funct3
// ---------------------------------------------------------------------------
module lsu_align
  import core_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic        illegal_f3;
  logic        bad_align;
  logic [31:0] rdata_shifted;

  // Loads allow the unsigned byte/half forms; stores only SB/SH/SW.
  always_comb begin
    illegal_f3 = 1'b0;
    if (is_store) begin
      illegal_f3 = (funct3 > F3_SW);
    end else begin
      illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end
  end

  // funct3[1:0] encodes the width for every legal load/store: 00 byte, 01 half, 10 word.
  always_comb begin
    bad_align = 1'b0;
    case (funct3[1:0])
      2'b01:   bad_align = addr_lo[0];
      2'b10:   bad_align = (addr_lo != 2'b00);
      default: bad_align = 1'b0;
    endcase
  end

  assign misalign = illegal_f3 || bad_align;

  always_comb begin
    be = 4'b0000;
    if (!misalign) begin
      case (funct3[1:0])
        2'b00:   be = 4'b0001 << addr_lo;
        2'b01:   be = 4'b0011 << addr_lo;
        2'b10:   be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  // Each byte lane picks its source byte so the enabled lanes carry the data
  // regardless of offset: bytes repeat every lane, halves every other lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      case (funct3[1:0])
        2'b00:   wdata[8*gi +: 8] = rs2[7:0];
        2'b01:   wdata[8*gi +: 8] = rs2[8*(gi % 2) +: 8];
        default: wdata[8*gi +: 8] = rs2[8*gi +: 8];
      endcase
    end
  end

  assign rdata_shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_LB:   load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3_LH:   load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3_LW:   load_data = rdata_shifted;
      F3_LBU:  load_data = {24'h0, rdata_shifted[7:0]};
      F3_LHU:  load_data = {16'h0, rdata_shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory-access pipeline stage between EX and WB.
//   clk, reset_i           clock and synchronous active-high reset
//   EX_MEM_*_i / MEM_EX_get_o   give/get input from EX (instr, ALU result, rs2)
//   MEM_WB_*_o / WB_MEM_get_i   give/get output to WB (instr, final data)
//   dmem_*                 data-memory port, req held until gnt, then rvalid
//   misalign_o             one-cycle pulse when an access is rejected
// Non-memory instructions pass through with one cycle of latency; in OUT the
// stage accepts from EX in the same cycle WB takes, so ALU ops stream without
// bubbles.
// ---------------------------------------------------------------------------
module mem_stage
  import core_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               EX_MEM_give_i,
  output logic               MEM_EX_get_o,
  input  logic [31:0]        EX_MEM_instruction_i,
  input  logic [BITSIZE-1:0] EX_MEM_d_i,
  input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
  output logic               MEM_WB_give_o,
  input  logic               WB_MEM_get_i,
  output logic [31:0]        MEM_WB_instruction_o,
  output logic [BITSIZE-1:0] MEM_WB_d_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic [BITSIZE-1:0] dmem_addr_o,
  output logic [3:0]         dmem_be_o,
  output logic [BITSIZE-1:0] dmem_wdata_o,
  input  logic               dmem_gnt_i,
  input  logic               dmem_rvalid_i,
  input  logic [BITSIZE-1:0] dmem_rdata_i,
  output logic               misalign_o
);

  if (BITSIZE != 32) begin : g_bitsize_check
    $error("mem_stage: only BITSIZE = 32 is supported");
  end

  mem_state_e         state_reg, state_next;
  logic [31:0]        instr_reg, instr_next;
  logic [BITSIZE-1:0] addr_reg, addr_next;
  logic [BITSIZE-1:0] rs2_reg, rs2_next;
  logic [BITSIZE-1:0] d_reg, d_next;
  logic               misalign_reg, misalign_next;

  logic               accept;
  logic               in_req;
  logic               store_reg;

  // The aligner is shared: while IDLE/OUT it looks at the incoming EX
  // instruction (for decode), in REQ/WAIT at the latched one (for the
  // memory access itself).
  logic               sel_ex;
  logic [6:0]         al_opcode;
  logic [2:0]         al_funct3;
  logic [1:0]         al_addr_lo;
  logic [31:0]        al_rs2;
  logic [3:0]         al_be;
  logic [31:0]        al_wdata;
  logic [31:0]        al_load_data;
  logic               al_misalign;

  assign sel_ex     = (state_reg == IDLE) || (state_reg == OUT);
  assign al_opcode  = sel_ex ? EX_MEM_instruction_i[6:0]   : instr_reg[6:0];
  assign al_funct3  = sel_ex ? EX_MEM_instruction_i[14:12] : instr_reg[14:12];
  assign al_addr_lo = sel_ex ? EX_MEM_d_i[1:0]             : addr_reg[1:0];
  assign al_rs2     = sel_ex ? EX_MEM_rs2_i                : rs2_reg;

  lsu_align u_align (
    .is_store  (al_opcode == OPC_STORE),
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .rs2       (al_rs2),
    .rdata     (dmem_rdata_i),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load_data),
    .misalign  (al_misalign)
  );

  // Get is held low while reset is asserted so nothing appears accepted.
  assign MEM_EX_get_o = !reset_i &&
                        ((state_reg == IDLE) || ((state_reg == OUT) && WB_MEM_get_i));
  assign accept       = EX_MEM_give_i && MEM_EX_get_o;

  assign in_req    = (state_reg == REQ);
  assign store_reg = (instr_reg[6:0] == OPC_STORE);

  assign MEM_WB_give_o        = (state_reg == OUT);
  assign MEM_WB_instruction_o = instr_reg;
  assign MEM_WB_d_o           = d_reg;
  assign misalign_o           = misalign_reg;

  // Memory port is driven only in REQ so it reads as all-zero otherwise.
  assign dmem_req_o   = in_req;
  assign dmem_we_o    = in_req && store_reg;
  assign dmem_addr_o  = in_req ? {addr_reg[BITSIZE-1:2], 2'b00} : '0;
  assign dmem_be_o    = in_req ? al_be : 4'b0000;
  assign dmem_wdata_o = (in_req && store_reg) ? al_wdata : '0;

  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    addr_next     = addr_reg;
    rs2_next      = rs2_reg;
    d_next        = d_reg;
    misalign_next = 1'b0;

    case (state_reg)
      IDLE: ;
      REQ: begin
        if (dmem_gnt_i) begin
          if (store_reg) begin
            state_next = OUT;
          end else if (dmem_rvalid_i) begin
            d_next     = al_load_data;
            state_next = OUT;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          d_next     = al_load_data;
          state_next = OUT;
        end
      end
      OUT: begin
        if (WB_MEM_get_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new EX transfer (from IDLE, or from OUT as WB drains) overrides the
    // above and is decoded straight away.
    if (accept) begin
      instr_next = EX_MEM_instruction_i;
      addr_next  = EX_MEM_d_i;
      rs2_next   = EX_MEM_rs2_i;
      if (!is_mem_op(EX_MEM_instruction_i[6:0])) begin
        d_next     = EX_MEM_d_i;
        state_next = OUT;
      end else if (al_misalign) begin
        d_next        = '0;
        misalign_next = 1'b1;
        state_next    = OUT;
      end else begin
        // Stores keep the ALU result as their writeback value; loads
        // overwrite it once rdata arrives.
        d_next     = EX_MEM_d_i;
        state_next = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_reg    <= IDLE;
      instr_reg    <= '0;
      addr_reg     <= '0;
      rs2_reg      <= '0;
      d_reg        <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      instr_reg    <= instr_next;
      addr_reg     <= addr_next;
      rs2_reg      <= rs2_next;
      d_reg        <= d_next;
      misalign_reg <= misalign_next;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage: directed self-checking bench for mem_stage.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        EX_MEM_give_i;
  logic        MEM_EX_get_o;
  logic [31:0] EX_MEM_instruction_i;
  logic [31:0] EX_MEM_d_i;
  logic [31:0] EX_MEM_rs2_i;
  logic        MEM_WB_give_o;
  logic        WB_MEM_get_i;
  logic [31:0] MEM_WB_instruction_o;
  logic [31:0] MEM_WB_d_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        misalign_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.BITSIZE(32)) dut (
    .clk                  (clk),
    .reset_i              (reset_i),
    .EX_MEM_give_i        (EX_MEM_give_i),
    .MEM_EX_get_o         (MEM_EX_get_o),
    .EX_MEM_instruction_i (EX_MEM_instruction_i),
    .EX_MEM_d_i           (EX_MEM_d_i),
    .EX_MEM_rs2_i         (EX_MEM_rs2_i),
    .MEM_WB_give_o        (MEM_WB_give_o),
    .WB_MEM_get_i         (WB_MEM_get_i),
    .MEM_WB_instruction_o (MEM_WB_instruction_o),
    .MEM_WB_d_o           (MEM_WB_d_o),
    .dmem_req_o           (dmem_req_o),
    .dmem_we_o            (dmem_we_o),
    .dmem_addr_o          (dmem_addr_o),
    .dmem_be_o            (dmem_be_o),
    .dmem_wdata_o         (dmem_wdata_o),
    .dmem_gnt_i           (dmem_gnt_i),
    .dmem_rvalid_i        (dmem_rvalid_i),
    .dmem_rdata_i         (dmem_rdata_i),
    .misalign_o           (misalign_o)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  task automatic give_ex(input logic [31:0] instr, input logic [31:0] d, input logic [31:0] rs2);
    EX_MEM_give_i        = 1'b1;
    EX_MEM_instruction_i = instr;
    EX_MEM_d_i           = d;
    EX_MEM_rs2_i         = rs2;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step();
    step();
    checks++; if ({MEM_WB_give_o, MEM_EX_get_o, dmem_req_o, dmem_we_o, misalign_o} !== 5'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b exp=00000",
        {MEM_WB_give_o, MEM_EX_get_o, dmem_req_o, dmem_we_o, misalign_o}); end
    checks++; if ({MEM_WB_d_o, MEM_WB_instruction_o, dmem_addr_o, dmem_wdata_o, dmem_be_o} !== 132'h0)
      begin failures++; $display("FAIL reset_data got d=%h i=%h a=%h w=%h be=%h exp all 0",
        MEM_WB_d_o, MEM_WB_instruction_o, dmem_addr_o, dmem_wdata_o, dmem_be_o); end
    reset_i = 1'b0;
    #1;
    checks++; if (MEM_EX_get_o !== 1'b1)
      begin failures++; $display("FAIL reset_idle_get got=%b exp=1", MEM_EX_get_o); end
  endtask

  task automatic test_alu_passthrough();
    WB_MEM_get_i = 1'b1;
    give_ex(32'h0420_0093, 32'h0000_0042, 32'h0);
    step();
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'h42 || MEM_WB_instruction_o !== 32'h0420_0093)
      begin failures++; $display("FAIL alu1 got give=%b d=%h i=%h exp give=1 d=00000042 i=04200093",
        MEM_WB_give_o, MEM_WB_d_o, MEM_WB_instruction_o); end
    give_ex(32'h0550_0113, 32'h0000_0055, 32'h0);
    #1;
    checks++; if (MEM_EX_get_o !== 1'b1)
      begin failures++; $display("FAIL alu_b2b_get got=%b exp=1", MEM_EX_get_o); end
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'h55 || MEM_WB_instruction_o !== 32'h0550_0113)
      begin failures++; $display("FAIL alu2 got give=%b d=%h i=%h exp give=1 d=00000055 i=05500113",
        MEM_WB_give_o, MEM_WB_d_o, MEM_WB_instruction_o); end
    step();
    checks++; if (MEM_WB_give_o !== 1'b0 || dmem_req_o !== 1'b0)
      begin failures++; $display("FAIL alu_drain got give=%b req=%b exp 0 0", MEM_WB_give_o, dmem_req_o); end
  endtask

  task automatic test_store_byte();
    int req_cycles;
    req_cycles = 0;
    WB_MEM_get_i = 1'b1;
    give_ex(mk_instr(7'b0100011, 3'b000, 5'd0), 32'h0000_0103, 32'h1234_56AB);
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (dmem_addr_o !== 32'h100 || dmem_be_o !== 4'b1000 || dmem_wdata_o !== 32'hABAB_ABAB || dmem_we_o !== 1'b1)
      begin failures++; $display("FAIL sb_port got a=%h be=%b w=%h we=%b exp a=00000100 be=1000 w=abababab we=1",
        dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o); end
    for (int c = 0; c < 3; c++) begin
      if (dmem_req_o === 1'b1) req_cycles++;
      dmem_gnt_i = (c == 2);
      step();
    end
    dmem_gnt_i = 1'b0;
    checks++; if (req_cycles !== 3)
      begin failures++; $display("FAIL sb_req_cycles got=%0d exp=3", req_cycles); end
    checks++; if (MEM_WB_give_o !== 1'b1 || dmem_req_o !== 1'b0 || MEM_WB_d_o !== 32'h103)
      begin failures++; $display("FAIL sb_done got give=%b req=%b d=%h exp give=1 req=0 d=00000103",
        MEM_WB_give_o, dmem_req_o, MEM_WB_d_o); end
    step();
  endtask

  task automatic run_load_half(input logic [2:0] f3, input logic [31:0] exp_d, input string name);
    WB_MEM_get_i = 1'b1;
    give_ex(mk_instr(7'b0000011, f3, 5'd5), 32'h0000_0202, 32'h0);
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== 4'b1100 || dmem_addr_o !== 32'h200)
      begin failures++; $display("FAIL %s_port got req=%b we=%b be=%b a=%h exp req=1 we=0 be=1100 a=00000200",
        name, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o); end
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    step();
    step();
    checks++; if (MEM_WB_give_o !== 1'b0 || dmem_req_o !== 1'b0)
      begin failures++; $display("FAIL %s_wait got give=%b req=%b exp 0 0", name, MEM_WB_give_o, dmem_req_o); end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h8001_7FFF;
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== exp_d)
      begin failures++; $display("FAIL %s_data got give=%b d=%h exp give=1 d=%h",
        name, MEM_WB_give_o, MEM_WB_d_o, exp_d); end
    step();
  endtask

  task automatic test_load_half();
    run_load_half(3'b001, 32'hFFFF_8001, "lh");
    run_load_half(3'b101, 32'h0000_8001, "lhu");
  endtask

  task automatic run_reject(input logic [2:0] f3, input logic [31:0] addr, input string name);
    int req_seen;
    int pulses;
    req_seen = 0;
    pulses   = 0;
    WB_MEM_get_i = 1'b1;
    give_ex(mk_instr(7'b0000011, f3, 5'd7), addr, 32'h0);
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'h0)
      begin failures++; $display("FAIL %s_result got give=%b d=%h exp give=1 d=00000000",
        name, MEM_WB_give_o, MEM_WB_d_o); end
    for (int c = 0; c < 3; c++) begin
      if (misalign_o === 1'b1) pulses++;
      if (dmem_req_o === 1'b1) req_seen++;
      step();
    end
    checks++; if (pulses !== 1 || req_seen !== 0)
      begin failures++; $display("FAIL %s_pulse got pulses=%0d reqs=%0d exp 1 0", name, pulses, req_seen); end
  endtask

  task automatic test_misalign();
    run_reject(3'b010, 32'h0000_0301, "lw_mis");
    run_reject(3'b011, 32'h0000_0300, "ld_illegal");
  endtask

  task automatic test_back_to_back();
    WB_MEM_get_i = 1'b0;
    give_ex(mk_instr(7'b0000011, 3'b010, 5'd9), 32'h0000_0400, 32'h0);
    step();
    give_ex(32'h0770_0193, 32'h0000_0077, 32'h0);
    dmem_gnt_i    = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEAD_BEEF;
    step();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL lw_same_cycle got give=%b d=%h exp give=1 d=deadbeef",
        MEM_WB_give_o, MEM_WB_d_o); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'hDEAD_BEEF || MEM_EX_get_o !== 1'b0 ||
                    MEM_WB_instruction_o !== mk_instr(7'b0000011, 3'b010, 5'd9))
        begin failures++; $display("FAIL stall_%0d got give=%b d=%h get=%b i=%h exp give=1 d=deadbeef get=0 i=%h",
          c, MEM_WB_give_o, MEM_WB_d_o, MEM_EX_get_o, MEM_WB_instruction_o, mk_instr(7'b0000011, 3'b010, 5'd9)); end
      step();
    end
    WB_MEM_get_i = 1'b1;
    #1;
    checks++; if (MEM_EX_get_o !== 1'b1)
      begin failures++; $display("FAIL release_get got=%b exp=1", MEM_EX_get_o); end
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'h77)
      begin failures++; $display("FAIL after_stall got give=%b d=%h exp give=1 d=00000077",
        MEM_WB_give_o, MEM_WB_d_o); end
    step();
  endtask

  task automatic test_reset_mid();
    WB_MEM_get_i = 1'b1;
    give_ex(mk_instr(7'b0000011, 3'b010, 5'd3), 32'h0000_0500, 32'h0);
    step();
    EX_MEM_give_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    reset_i = 1'b1;
    step();
    checks++; if ({MEM_WB_give_o, MEM_EX_get_o, dmem_req_o, misalign_o} !== 4'b0 || MEM_WB_d_o !== 32'h0 ||
                  MEM_WB_instruction_o !== 32'h0 || dmem_be_o !== 4'h0 || dmem_addr_o !== 32'h0)
      begin failures++; $display("FAIL midreset got give=%b get=%b req=%b mis=%b d=%h i=%h be=%b a=%h exp all 0",
        MEM_WB_give_o, MEM_EX_get_o, dmem_req_o, misalign_o, MEM_WB_d_o, MEM_WB_instruction_o, dmem_be_o, dmem_addr_o); end
    reset_i       = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1357_9BDF;
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    checks++; if (MEM_WB_give_o !== 1'b0 || MEM_WB_d_o !== 32'h0 || MEM_EX_get_o !== 1'b1)
      begin failures++; $display("FAIL stray_rvalid got give=%b d=%h get=%b exp give=0 d=00000000 get=1",
        MEM_WB_give_o, MEM_WB_d_o, MEM_EX_get_o); end
    give_ex(32'h0990_0213, 32'h0000_0099, 32'h0);
    step();
    EX_MEM_give_i = 1'b0;
    checks++; if (MEM_WB_give_o !== 1'b1 || MEM_WB_d_o !== 32'h99)
      begin failures++; $display("FAIL post_reset_alu got give=%b d=%h exp give=1 d=00000099",
        MEM_WB_give_o, MEM_WB_d_o); end
    step();
  endtask

  initial begin
    reset_i              = 1'b1;
    EX_MEM_give_i        = 1'b0;
    EX_MEM_instruction_i = 32'h0;
    EX_MEM_d_i           = 32'h0;
    EX_MEM_rs2_i         = 32'h0;
    WB_MEM_get_i         = 1'b0;
    dmem_gnt_i           = 1'b0;
    dmem_rvalid_i        = 1'b0;
    dmem_rdata_i         = 32'h0;

    test_reset();
    test_alu_passthrough();
    test_store_byte();
    test_load_half();
    test_misalign();
    test_back_to_back();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
